// File: rtl/ex_result_buffer.sv
// EX-stage result buffer: first-word-fall-through FIFO with drop and flag statistics.
// Optional flag counters are built when EX_RESULT_BUFFER_FLAG_STATS_EN is defined.
module ex_result_buffer #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CTRL_W-1:0]        in_control,
    input  logic [DATA_W-1:0]        in_alu_data,
    input  logic [DATA_W-1:0]        in_memory_data,
    input  logic                     in_overflow_flag,
    input  logic                     in_zero_flag,
    input  logic                     in_compflg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_control,
    output logic [DATA_W-1:0]        out_alu_data,
    output logic [DATA_W-1:0]        out_memory_data,
    output logic                     out_overflow_flag,
    output logic                     out_zero_flag,
    output logic                     out_compflg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [CNT_W-1:0]         drop_count,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [CNT_W-1:0]         zero_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

    typedef struct packed {
        logic [CTRL_W-1:0] control;
        logic [DATA_W-1:0] alu_data;
        logic [DATA_W-1:0] memory_data;
        logic              overflow;
        logic              zero;
        logic              compflg;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic               pop;
    logic               push;
    logic               drop;

    // A pop frees a slot in the same cycle, so a full buffer still accepts a push.
    assign pop  = (occ != '0) && out_ready;
    assign push = in_valid && ((occ != FULL_LVL) || pop);
    assign drop = in_valid && !push;

    // NOTE: entry storage carries no reset; validity comes only from the pointers and occ.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= '{control:     in_control,
                             alu_data:    in_alu_data,
                             memory_data: in_memory_data,
                             overflow:    in_overflow_flag,
                             zero:        in_zero_flag,
                             compflg:     in_compflg};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (occ != '0);
    assign count     = occ;
    assign full      = (occ == FULL_LVL);

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        out_control       = '0;
        out_alu_data      = '0;
        out_memory_data   = '0;
        out_overflow_flag = 1'b0;
        out_zero_flag     = 1'b0;
        out_compflg       = 1'b0;
        if (out_valid) begin
            out_control       = head.control;
            out_alu_data      = head.alu_data;
            out_memory_data   = head.memory_data;
            out_overflow_flag = head.overflow;
            out_zero_flag     = head.zero;
            out_compflg       = head.compflg;
        end
    end

`ifdef EX_RESULT_BUFFER_FLAG_STATS_EN
    logic [CNT_W-1:0] ovf_q;
    logic [CNT_W-1:0] zero_q;

    // Only accepted pushes are counted; dropped results never reach the statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= '0;
            zero_q <= '0;
        end else if (push) begin
            if (in_overflow_flag && (ovf_q != '1))  ovf_q  <= ovf_q + 1'b1;
            if (in_zero_flag && (zero_q != '1))     zero_q <= zero_q + 1'b1;
        end
    end

    assign ovf_count  = ovf_q;
    assign zero_count = zero_q;
`else
    assign ovf_count  = '0;
    assign zero_count = '0;
`endif

endmodule

// File: doc/ex_result_buffer.md
EX_RESULT_BUFFER -- requirements
Module: ex_result_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the alu_data and memory_data fields.
REQ-002 The block SHALL have parameter CTRL_W, default 16, giving the width of the packed control word.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the entry count; legal values are powers of two, minimum 2.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-005 The block SHALL have these ports:
  - clk  in  1  clock; all state updates on the rising edge
  - rst  in  1  reset, synchronous, active-high
  - in_valid  in  1  EX-stage result valid this cycle
  - in_control  in  CTRL_W  packed control word
  - in_alu_data  in  DATA_W  ALU result
  - in_memory_data  in  DATA_W  store data
  - in_overflow_flag  in  1  ALU overflow
  - in_zero_flag  in  1  ALU zero
  - in_compflg  in  1  compare flag
  - out_valid  out  1  head entry available
  - out_ready  in  1  consumer accepts head
  - out_control, out_alu_data, out_memory_data  out  CTRL_W / DATA_W / DATA_W  head entry fields
  - out_overflow_flag, out_zero_flag, out_compflg  out  1 each  head entry flags
  - count  out  $clog2(DEPTH)+1  occupied entries
  - full  out  1  count == DEPTH
  - drop_count  out  CNT_W  results lost because the buffer was full
  - ovf_count, zero_count  out  CNT_W each  flag statistics

Function
REQ-006 The buffer SHALL store each entry as {control, alu_data, memory_data, overflow, zero, compflg}.
REQ-007 The buffer SHALL have no input back-pressure; the EX stage never stalls.
REQ-008 A push SHALL be accepted when in_valid=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-009 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-010 Output SHALL be first-word-fall-through:
  - out_valid = (count != 0)
  - head fields are driven combinationally from storage
  - all out_* data and flag fields are 0 while out_valid=0
REQ-011 A push into an empty buffer SHALL appear at the outputs on the following cycle (latency 1); data SHALL never bypass storage combinationally.
REQ-012 Simultaneous push and pop SHALL leave count unchanged, including when count=0 is not the case and count=DEPTH.
REQ-013 When count=0, a pop SHALL NOT occur, because out_valid=0.
REQ-014 Read and write pointers SHALL wrap modulo DEPTH.
REQ-015 The buffer SHALL preserve entry order strictly (FIFO).
REQ-016 When in_valid=1 and the push is not accepted:
  - the input is discarded
  - drop_count increments by 1, saturating at 2^CNT_W-1
REQ-017 Outputs count and full SHALL be registered-state derived, with no combinational path from in_valid.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL clear the read pointer, write pointer, count, drop_count, ovf_count and zero_count to 0.
REQ-019 During and after reset, out_valid=0, full=0, and all out_* fields=0.
REQ-020 Entry storage SHALL NOT be reset.
REQ-021 rst SHALL take priority over any simultaneous push or pop; a push or pop in the reset cycle is lost and not counted.

Configuration
REQ-022 With macro EX_RESULT_BUFFER_FLAG_STATS_EN defined, each accepted push SHALL apply these saturating increments:
  - ovf_count increments by 1 when in_overflow_flag=1
  - zero_count increments by 1 when in_zero_flag=1
  - dropped inputs do not count
REQ-023 Without EX_RESULT_BUFFER_FLAG_STATS_EN, ports ovf_count and zero_count SHALL remain present and tied to 0, and no counter registers SHALL be inferred.

Verification
REQ-024 Reset, then one push of alu_data=0x0000_0005 with zero=0 -> out_valid=1 one cycle later with out_alu_data=0x5; count=1.
REQ-025 DEPTH=4, out_ready=0, push 6 consecutive values 1..6 -> full=1 after the 4th push; drop_count=2; popping yields 1,2,3,4.
REQ-026 Full buffer, in_valid=1 and out_ready=1 in the same cycle -> push accepted, count stays 4, drop_count unchanged.
REQ-027 Push/pop 10 entries through DEPTH=4 at steady state -> pointers wrap and the output order is preserved.
REQ-028 Macro defined, push 3 entries with overflow=1,0,1 and zero=1,1,0 -> ovf_count=2, zero_count=2; without the macro both read 0.
REQ-029 Assert rst while count=3 -> the next cycle count=0, out_valid=0, out_alu_data=0, and drop_count=0.
